serializador_param: RTL and testbench
=====================================

// Module: serializador_param
// PURPOSE
//  Parametrised parallel-to-serial converter for the PHY transmit path, single clock domain (bit clock).
//  Accepts WIDTH-bit words over a valid/ready handshake into a one-word holding register, emits one bit
//  per clk_32f cycle as a continuous stream, and inserts IDLE_SYMBOL at any word boundary with no data pending.
//  Adds an enable-controlled start/stop FSM, selectable bit order and a word-boundary marker.
// PARAMETERS
//  WIDTH        8       word width in bits; legal range >=2; bit counter is $clog2(WIDTH) bits
//  IDLE_SYMBOL  8'hBC   WIDTH-bit filler word sent when no data is pending (COM symbol by default)
//  MSB_FIRST    1       1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
// PORTS
//  clk_32f      in   1      bit clock; all logic on its rising edge
//  reset        in   1      synchronous, active-high
//  en           in   1      1: run / keep transmitting; 0: stop at the next word boundary
//  data_in      in   WIDTH  parallel word
//  valid_in     in   1      data_in is valid
//  ready_out    out  1      holding register can accept; transfer = valid_in & ready_out at a rising edge
//  data_out     out  1      serial bit, registered
//  valid_out    out  1      data_out carries a stream bit (data or idle)
//  word_start   out  1      high in the cycle data_out carries the first bit of a word
//  idle_out     out  1      high for every bit of an inserted IDLE_SYMBOL word
// BEHAVIOUR
//  Reset: data_out=0, valid_out=0, word_start=0, idle_out=0, hold empty, bit cnt=0, state=ST_STOP.
//   reset overrides everything at any cycle, including mid-word. The partial word and the held word are discarded.
//  ready_out (combinational) = ~hold_vld | load_edge. A word can be accepted on the same edge that empties the hold.
//   Accepting while hold is full and no load occurs is impossible by construction. data_in is ignored when ready_out=0.
//  Load edge: an edge in ST_STOP with en=1, or an edge in ST_RUN with cnt==WIDTH-1.
//   At a load edge the word is hold_data if hold_vld, otherwise IDLE_SYMBOL. There is no bypass from data_in:
//   a word accepted on the load edge itself goes to hold and is sent at the next boundary.
//   The load edge registers the first bit into data_out, word_start<=1, valid_out<=1, and idle_out<=(word is idle).
//   It also sets cnt<=0, loads the remaining bits into the shift register, and clears hold_vld unless refilled on that edge.
//  ST_RUN non-load edge: data_out<=next bit in MSB_FIRST order, cnt<=cnt+1, word_start<=0, idle_out holds.
//   Load edges occur every WIDTH cycles, so the stream has no gaps.
//  ST_RUN at cnt==WIDTH-1 with en=0: no load. Go to ST_STOP with data_out<=0, valid_out<=0, word_start<=0, idle_out<=0.
//   A word in progress always completes, whatever en does mid-word.
//  ST_STOP: outputs stay 0 and the hold is kept. ready_out=~hold_vld. With en=1 the edge is a load edge -> ST_RUN.
//  Latency: with hold empty, a word accepted at edge A appears at the first load edge after A.
//   Its first bit is on data_out from that edge onward. Worst case is WIDTH cycles in ST_RUN.
//  Sustained throughput: 1 word per WIDTH cycles. ready_out is high exactly on load edges while the source is back-to-back.
// CONFIGURATION
//  SERIALIZADOR_IDLE_CNT_EN defined: adds output idle_count [15:0].
//   It resets to 0, increments on each load edge that loads IDLE_SYMBOL, and saturates at 16'hFFFF.
//  Not defined: the port and the counter do not exist; all other behaviour is identical.
// TESTING
//  1 reset 2 cycles, en=1, valid_in=0 -> first edge after release: word_start=1. Bits 1,0,1,1,1,1,0,0 repeat every 8 cycles, idle_out=1.
//  2 steady run, single valid_in with 8'hA5 accepted mid-word -> next boundary sends 1,0,1,0,0,1,0,1 with idle_out=0.
//    The following word is BC again.
//  3 words 8'h01,8'h02,8'h03 with valid_in held -> no idle between them; ready_out pulses once per 8 cycles at load edges.
//  4 en=0 at cnt=3 with 8'h5A held -> current word finishes, then valid_out=0 and data_out=0.
//    After en=1, 8'h5A is the first word sent.
//  5 reset asserted at cnt=4 with hold full -> next cycle all outputs 0, ready_out=1, and held word is never sent.
//  6 WIDTH=10, MSB_FIRST=0, IDLE_SYMBOL=10'h17C -> LSB first: bits 0,0,1,1,1,1,1,0,1,0, 10-cycle word period.
//    With SERIALIZADOR_IDLE_CNT_EN defined, idle_count=3 after 3 idle words.

Source files
------------

// File: rtl/serializador_param_if.sv
// Word-in / bit-out bundle for serializador_param; master is the word source, slave is the serializer.
interface serializador_param_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;
  logic             data_out;
  logic             valid_out;
  logic             word_start;
  logic             idle_out;

  modport master (
    output en, data_in, valid_in,
    input  ready_out, data_out, valid_out, word_start, idle_out
  );

  modport slave (
    input  en, data_in, valid_in,
    output ready_out, data_out, valid_out, word_start, idle_out
  );
endinterface

// File: rtl/serializador_param.sv
// Parallel-to-serial PHY tx with one-word hold; IDLE_SYMBOL fills empty boundaries. Define SERIALIZADOR_IDLE_CNT_EN for idle_count.
// Latency up to WIDTH cycles from accept to first bit; ready_out = hold empty or load edge this cycle.
module serializador_param #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] IDLE_SYMBOL = 8'hBC,
  parameter bit               MSB_FIRST   = 1'b1
) (
  input  logic                 clk_32f,
  input  logic                 reset,
`ifdef SERIALIZADOR_IDLE_CNT_EN
  output logic [15:0]          idle_count,
`endif
  serializador_param_if.slave  bus
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {ST_STOP, ST_RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] hold_data;
  logic             hold_vld;
  logic             data_q;
  logic             valid_q;
  logic             word_start_q;
  logic             idle_q;

  logic             word_end;
  logic             load_edge;
  logic             accept;
  logic             next_is_idle;
  logic [WIDTH-1:0] next_word;

  assign word_end     = (state == ST_RUN) && (cnt == CNT_LAST);
  assign load_edge    = bus.en && ((state == ST_STOP) || word_end);
  assign bus.ready_out = ~hold_vld | load_edge;
  assign accept       = bus.valid_in & bus.ready_out;
  assign next_is_idle = ~hold_vld;
  assign next_word    = hold_vld ? hold_data : IDLE_SYMBOL;

  assign bus.data_out   = data_q;
  assign bus.valid_out  = valid_q;
  assign bus.word_start = word_start_q;
  assign bus.idle_out   = idle_q;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state        <= ST_STOP;
      cnt          <= '0;
      shift_q      <= '0;
      hold_data    <= '0;
      hold_vld     <= 1'b0;
      data_q       <= 1'b0;
      valid_q      <= 1'b0;
      word_start_q <= 1'b0;
      idle_q       <= 1'b0;
`ifdef SERIALIZADOR_IDLE_CNT_EN
      idle_count   <= '0;
`endif
    end else begin
      // A refill on the load edge wins over the clear, so the hold never drops a word.
      if (accept) begin
        hold_data <= bus.data_in;
        hold_vld  <= 1'b1;
      end else if (load_edge) begin
        hold_vld  <= 1'b0;
      end

      if (load_edge) begin
        state        <= ST_RUN;
        cnt          <= '0;
        valid_q      <= 1'b1;
        word_start_q <= 1'b1;
        idle_q       <= next_is_idle;
        if (MSB_FIRST) begin
          data_q  <= next_word[WIDTH-1];
          shift_q <= {next_word[WIDTH-2:0], 1'b0};
        end else begin
          data_q  <= next_word[0];
          shift_q <= {1'b0, next_word[WIDTH-1:1]};
        end
`ifdef SERIALIZADOR_IDLE_CNT_EN
        if (next_is_idle && (idle_count != 16'hFFFF)) begin
          idle_count <= idle_count + 16'd1;
        end
`endif
      end else if (word_end) begin
        state        <= ST_STOP;
        cnt          <= '0;
        data_q       <= 1'b0;
        valid_q      <= 1'b0;
        word_start_q <= 1'b0;
        idle_q       <= 1'b0;
      end else if (state == ST_RUN) begin
        cnt          <= cnt + 1'b1;
        word_start_q <= 1'b0;
        if (MSB_FIRST) begin
          data_q  <= shift_q[WIDTH-1];
          shift_q <= {shift_q[WIDTH-2:0], 1'b0};
        end else begin
          data_q  <= shift_q[0];
          shift_q <= {1'b0, shift_q[WIDTH-1:1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_serializador_param.sv
// Scoreboard bench: an 8-bit MSB-first instance with handshake traffic and a 10-bit LSB-first idle-only instance.
`timescale 1ns/1ps
module tb_serializador_param;

  localparam int W  = 8;
  localparam int W2 = 10;
  localparam logic [W-1:0]  IDLE8  = 8'hBC;
  localparam logic [W2-1:0] IDLE10 = 10'h17C;

  logic clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  logic reset;
  logic reset2;

  serializador_param_if #(.WIDTH(W))  bus  ();
  serializador_param_if #(.WIDTH(W2)) bus2 ();

`ifdef SERIALIZADOR_IDLE_CNT_EN
  logic [15:0] idle_count;
  logic [15:0] idle_count2;
`endif

  serializador_param #(.WIDTH(W), .IDLE_SYMBOL(IDLE8), .MSB_FIRST(1'b1)) dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
`ifdef SERIALIZADOR_IDLE_CNT_EN
    .idle_count (idle_count),
`endif
    .bus        (bus)
  );

  serializador_param #(.WIDTH(W2), .IDLE_SYMBOL(IDLE10), .MSB_FIRST(1'b0)) dut10 (
    .clk_32f    (clk_32f),
    .reset      (reset2),
`ifdef SERIALIZADOR_IDLE_CNT_EN
    .idle_count (idle_count2),
`endif
    .bus        (bus2)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge clk_32f) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Scoreboard entry: accepted word and the edge index on which it was accepted.
  typedef struct {
    logic [W-1:0] w;
    int           acc;
  } sb_t;
  sb_t sbq[$];

  bit           m_busy = 0;
  int           m_pos  = 0;
  logic [W-1:0] m_word;
  logic [W-1:0] m_exp;
  bit           m_exp_idle;
  bit           b2b_mode = 0;
  int           n_b2b    = 0;
  int           last_data_start = 0;
  bit           rst_cut  = 0;

  always @(negedge clk_32f) begin
    if (bus.valid_out === 1'b1 && bus.word_start === 1'b1) begin
      if (m_busy && !rst_cut) check("word_cut", m_pos, W);
      m_busy = 1;
      m_pos  = 0;
      m_word = '0;
      if (sbq.size() > 0 && sbq[0].acc < cyc) begin
        m_exp      = sbq[0].w;
        m_exp_idle = 0;
        void'(sbq.pop_front());
        if (b2b_mode) begin
          if (n_b2b > 0) check("b2b_gap", cyc - last_data_start, W);
          n_b2b++;
        end
        last_data_start = cyc;
      end else begin
        m_exp      = IDLE8;
        m_exp_idle = 1;
      end
      check("idle_flag_start", bus.idle_out, m_exp_idle);
    end
    if (m_busy) begin
      if (bus.valid_out !== 1'b1) begin
        if (!rst_cut) check("stream_gap", bus.valid_out, 1);
        m_busy = 0;
      end else begin
        m_word = {m_word[W-2:0], bus.data_out};
        m_pos++;
        if (m_pos == W) begin
          check("word_value", m_word, m_exp);
          check("idle_flag_end", bus.idle_out, m_exp_idle);
          m_busy = 0;
        end
      end
    end
  end

  bit            m2_busy = 0;
  int            m2_pos  = 0;
  int            m2_start = 0;
  int            n2_started = 0;
  int            n2 = 0;
  logic [W2-1:0] m2_word;

  always @(negedge clk_32f) begin
    if (bus2.valid_out === 1'b1 && bus2.word_start === 1'b1) begin
      if (n2_started > 0) check("w10_period", cyc - m2_start, W2);
      m2_start = cyc;
      n2_started++;
      m2_busy = 1;
      m2_pos  = 0;
      m2_word = '0;
      check("w10_idle_flag", bus2.idle_out, 1);
    end
    if (m2_busy && bus2.valid_out === 1'b1) begin
      m2_word[m2_pos] = bus2.data_out;
      m2_pos++;
      if (m2_pos == W2) begin
        check("w10_word", m2_word, IDLE10);
        m2_busy = 0;
        n2++;
`ifdef SERIALIZADOR_IDLE_CNT_EN
        check("w10_idle_count", idle_count2, n2);
`endif
      end
    end
  end

  task automatic step();
    @(negedge clk_32f);
    #1;
  endtask

  // Waits until the bit currently on data_out is bit k of a word.
  task automatic wait_cnt(input int k);
    int t;
    bit ok;
    t  = 0;
    ok = 0;
    while (t < 40 && !ok) begin
      if (m_busy && (m_pos - 1) == k) ok = 1;
      else begin
        step();
        t++;
      end
    end
    check("wait_cnt", ok, 1);
  endtask

  task automatic push_word(input logic [W-1:0] w, input bit load_chk);
    int t;
    bit ok;
    t  = 0;
    ok = 0;
    bus.data_in  = w;
    bus.valid_in = 1'b1;
    while (t < 64 && !ok) begin
      if (bus.ready_out === 1'b1) ok = 1;
      else begin
        step();
        t++;
      end
    end
    check("accept", ok, 1);
    if (ok) begin
      sbq.push_back('{w: w, acc: cyc + 1});
      step();
      if (load_chk) check("ready_at_load", bus.word_start, 1);
    end
    bus.valid_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, got %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int t;
    reset        = 1'b1;
    reset2       = 1'b1;
    bus.en       = 1'b1;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    bus2.en       = 1'b1;
    bus2.valid_in = 1'b0;
    bus2.data_in  = '0;

    step();
    step();
    check("rst_data_out", bus.data_out, 0);
    check("rst_valid_out", bus.valid_out, 0);
    check("rst_word_start", bus.word_start, 0);
    check("rst_idle_out", bus.idle_out, 0);
    check("rst_ready_out", bus.ready_out, 1);
    reset  = 1'b0;
    reset2 = 1'b0;

    step();
    check("first_word_start", bus.word_start, 1);
    check("first_valid", bus.valid_out, 1);
    check("first_idle", bus.idle_out, 1);
    check("first_bit", bus.data_out, 1);
    repeat (3 * W) step();

    // Single word accepted mid-word, followed by idle again.
    wait_cnt(3);
    push_word(8'hA5, 1'b0);
    repeat (3 * W) step();
    check("a5_drained", sbq.size(), 0);

    // Back-to-back source: ready only on load edges, no idle in between.
    b2b_mode = 1;
    n_b2b    = 0;
    push_word(8'h01, 1'b0);
    push_word(8'h02, 1'b1);
    push_word(8'h03, 1'b1);
    repeat (3 * W) step();
    b2b_mode = 0;
    check("b2b_words", n_b2b, 3);

    // Stop mid-word with a word held; it must be the first word after restart.
    wait_cnt(1);
    push_word(8'h5A, 1'b0);
    wait_cnt(3);
    bus.en = 1'b0;
    t = 0;
    while (bus.valid_out === 1'b1 && t < 20) begin
      step();
      t++;
    end
    check("stop_latency", t, 5);
    check("stop_data_out", bus.data_out, 0);
    check("stop_word_start", bus.word_start, 0);
    check("stop_idle_out", bus.idle_out, 0);
    check("stop_ready_hold_full", bus.ready_out, 0);
    repeat (4) step();
    check("stop_stays", bus.valid_out, 0);
    bus.en = 1'b1;
    step();
    check("restart_word_start", bus.word_start, 1);
    check("restart_not_idle", bus.idle_out, 0);
    repeat (2 * W) step();
    check("5a_drained", sbq.size(), 0);

    // Reset mid-word with the hold full: both words are discarded.
    wait_cnt(1);
    push_word(8'h3C, 1'b0);
    wait_cnt(4);
    reset   = 1'b1;
    rst_cut = 1;
    sbq.delete();
    step();
    check("mid_rst_data_out", bus.data_out, 0);
    check("mid_rst_valid_out", bus.valid_out, 0);
    check("mid_rst_word_start", bus.word_start, 0);
    check("mid_rst_idle_out", bus.idle_out, 0);
    check("mid_rst_ready_out", bus.ready_out, 1);
    reset = 1'b0;
    step();
    rst_cut = 0;
    check("post_rst_word_start", bus.word_start, 1);
    check("post_rst_idle", bus.idle_out, 1);
    repeat (3 * W) step();

    bus.en = 1'b0;
    t = 0;
    while (bus.valid_out === 1'b1 && t < 20) begin
      step();
      t++;
    end
    check("final_stopped", bus.valid_out, 0);
    check("sb_empty", sbq.size(), 0);
    check("w10_enough_words", (n2 >= 3), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
